// File: rtl/snake_pkg.sv
// Shared types and screen constants for the snake game datapath.
// Direction encoding matches the dir_req input of the body engine.
package snake_pkg;

    localparam int unsigned ScreenW = 160;
    localparam int unsigned ScreenH = 120;

    typedef enum logic [1:0] {
        DirRight = 2'b00,
        DirDown  = 2'b01,
        DirUp    = 2'b10,
        DirLeft  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StErase,
        StShift,
        StCheck,
        StDraw,
        StDead
    } state_t;

    // Opposite directions are bitwise complements of each other.
    function automatic logic is_reverse(input dir_t cur, input dir_t req);
        return req == dir_t'(~cur);
    endfunction

endpackage

// File: rtl/seg_pixel_scan.sv
// Row-major SEG x SEG pixel counter shared by the init, erase and draw scans.
// Wraps to the origin after the last pixel so the next scan starts clean.
module seg_pixel_scan #(
    parameter int unsigned SEG = 10,
    parameter int unsigned CW  = $clog2(SEG)
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          en,
    output logic [CW-1:0] xc,
    output logic [CW-1:0] yc,
    output logic          start,
    output logic          last
);

    logic [CW-1:0] xc_q, yc_q;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            xc_q <= '0;
            yc_q <= '0;
        end else if (en) begin
            if (xc_q == CW'(SEG - 1)) begin
                xc_q <= '0;
                yc_q <= (yc_q == CW'(SEG - 1)) ? '0 : yc_q + 1'b1;
            end else begin
                xc_q <= xc_q + 1'b1;
            end
        end
    end

    assign xc    = xc_q;
    assign yc    = yc_q;
    assign start = (xc_q == '0) && (yc_q == '0);
    assign last  = (xc_q == CW'(SEG - 1)) && (yc_q == CW'(SEG - 1));

endmodule

// File: rtl/snake_body_engine.sv
// Snake segment store and incremental renderer: erases the tail, shifts the body,
// checks the new head against walls and body, then draws it into the VGA adapter.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int unsigned    MAX_LEN  = 16,
    parameter int unsigned    INIT_LEN = 2,
    parameter int unsigned    SEG      = 10,
    parameter int unsigned    XW       = 8,
    parameter int unsigned    YW       = 7,
    parameter int unsigned    XSCREEN  = ScreenW,
    parameter int unsigned    YSCREEN  = ScreenH,
    parameter logic [XW-1:0]  X0       = XW'(39),
    parameter logic [YW-1:0]  Y0       = YW'(59),
    parameter logic [2:0]     BODY_COL = 3'b010,
    parameter logic [2:0]     BG_COL   = 3'b000,
    localparam int unsigned   LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          step,
    input  logic [1:0]    dir_req,
    input  logic          dir_valid,
    input  logic          grow,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [2:0]    colour,
    output logic          plot,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] len,
    output logic          busy,
    output logic          collide
);

    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam int unsigned CW = $clog2(SEG);

    state_t        state_q, state_d;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [LW-1:0] len_q;
    dir_t          dir_q;
    logic          grow_pend_q;
    logic [IW-1:0] init_idx_q, chk_idx_q, cur_idx, tail_idx;
    logic          wall_q, wall_d, self_hit, can_grow;
    logic [XW:0]   nx_ext;
    logic [YW:0]   ny_ext;

    logic          scan_en, scan_start, scan_last;
    logic [CW-1:0] xc, yc;
    logic [2:0]    scan_colour;

    logic [XW-1:0] base_x_q, base_x, pix_x_q;
    logic [YW-1:0] base_y_q, base_y, pix_y_q;
    logic [2:0]    colour_q;
    logic          plot_q;

    seg_pixel_scan #(
        .SEG (SEG),
        .CW  (CW)
    ) u_scan (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .en       (scan_en),
        .xc       (xc),
        .yc       (yc),
        .start    (scan_start),
        .last     (scan_last)
    );

    assign tail_idx = IW'(len_q - 1'b1);
    assign can_grow = grow_pend_q && (len_q < LW'(MAX_LEN));
    assign self_hit = (seg_x_q[chk_idx_q] == seg_x_q[0]) && (seg_y_q[chk_idx_q] == seg_y_q[0]);

    // One extra bit keeps a step off the left/top edge visible as a negative value.
    always_comb begin
        nx_ext = {1'b0, seg_x_q[0]};
        ny_ext = {1'b0, seg_y_q[0]};
        unique case (dir_q)
            DirRight: nx_ext = {1'b0, seg_x_q[0]} + (XW+1)'(SEG);
            DirLeft:  nx_ext = {1'b0, seg_x_q[0]} - (XW+1)'(SEG);
            DirDown:  ny_ext = {1'b0, seg_y_q[0]} + (YW+1)'(SEG);
            DirUp:    ny_ext = {1'b0, seg_y_q[0]} - (YW+1)'(SEG);
        endcase
        wall_d = nx_ext[XW] || ny_ext[YW]
              || (({1'b0, nx_ext} + (XW+2)'(SEG)) > (XW+2)'(XSCREEN))
              || (({1'b0, ny_ext} + (YW+2)'(SEG)) > (YW+2)'(YSCREEN));
    end

    always_comb begin
        state_d     = state_q;
        scan_en     = 1'b0;
        scan_colour = BG_COL;
        cur_idx     = '0;
        unique case (state_q)
            StInit: begin
                scan_en     = 1'b1;
                scan_colour = BODY_COL;
                cur_idx     = init_idx_q;
                if (scan_last && (init_idx_q == tail_idx)) state_d = StIdle;
            end
            StIdle: begin
                if (step) state_d = can_grow ? StShift : StErase;
            end
            StErase: begin
                scan_en = 1'b1;
                cur_idx = tail_idx;
                if (scan_last) state_d = StShift;
            end
            StShift: state_d = StCheck;
            StCheck: begin
                if (wall_q || self_hit) state_d = StDead;
                else if (chk_idx_q == tail_idx) state_d = StDraw;
            end
            StDraw: begin
                scan_en     = 1'b1;
                scan_colour = BODY_COL;
                if (scan_last) state_d = StIdle;
            end
            StDead: state_d = StDead;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q     <= StInit;
            len_q       <= LW'(INIT_LEN);
            dir_q       <= DirRight;
            grow_pend_q <= 1'b0;
            init_idx_q  <= '0;
            chk_idx_q   <= '0;
            wall_q      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= X0 - XW'(i * SEG);
                seg_y_q[i] <= Y0;
            end
        end else begin
            state_q <= state_d;
            if (dir_valid && !is_reverse(dir_q, dir_t'(dir_req))) dir_q <= dir_t'(dir_req);
            // A grow arriving in the shift cycle survives for the following move.
            if (grow) grow_pend_q <= 1'b1;
            else if (state_q == StShift) grow_pend_q <= 1'b0;
            if (state_q == StInit && scan_last) init_idx_q <= init_idx_q + 1'b1;
            if (state_q == StCheck) chk_idx_q <= chk_idx_q + 1'b1;
            if (state_q == StShift) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_q[i] <= seg_x_q[i-1];
                    seg_y_q[i] <= seg_y_q[i-1];
                end
                seg_x_q[0] <= nx_ext[XW-1:0];
                seg_y_q[0] <= ny_ext[YW-1:0];
                wall_q     <= wall_d;
                chk_idx_q  <= IW'(1);
                if (can_grow) len_q <= len_q + 1'b1;
            end
        end
    end

    // Segment origin is latched on the first pixel so the store mux is used once per scan.
    assign base_x = scan_start ? seg_x_q[cur_idx] : base_x_q;
    assign base_y = scan_start ? seg_y_q[cur_idx] : base_y_q;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            plot_q   <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            colour_q <= BG_COL;
            base_x_q <= '0;
            base_y_q <= '0;
        end else begin
            plot_q <= scan_en;
            if (scan_en) begin
                base_x_q <= base_x;
                base_y_q <= base_y;
                pix_x_q  <= base_x + XW'(xc);
                pix_y_q  <= base_y + YW'(yc);
                colour_q <= scan_colour;
            end
        end
    end

    assign pix_x   = pix_x_q;
    assign pix_y   = pix_y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign head_x  = seg_x_q[0];
    assign head_y  = seg_y_q[0];
    assign len     = len_q;
    assign busy    = (state_q != StIdle);
    assign collide = (state_q == StDead);

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: a behavioural snake model pushes expected
// pixels into a queue and a negedge monitor pops and compares every plotted pixel.
module tb_snake_body_engine;

    localparam int unsigned MAXL = 5;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic       dir_valid = 1'b0;
    logic       grow = 1'b0;
    logic [7:0] pix_x, head_x;
    logic [6:0] pix_y, head_y;
    logic [2:0] colour;
    logic       plot, busy, collide;
    logic [2:0] len;

    snake_body_engine #(.MAX_LEN(MAXL)) dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .step      (step),
        .dir_req   (dir_req),
        .dir_valid (dir_valid),
        .grow      (grow),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .colour    (colour),
        .plot      (plot),
        .head_x    (head_x),
        .head_y    (head_y),
        .len       (len),
        .busy      (busy),
        .collide   (collide)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int          n_assert = 0;
    int          n_fail = 0;
    int          plot_cnt = 0;
    bit          mon_en = 1'b0;
    logic [17:0] exp_q[$];

    int mx[MAXL];
    int my[MAXL];
    int mlen, mdir;
    bit mgrow, mdead;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (mon_en && plot) begin
            logic [17:0] e;
            plot_cnt++;
            chk("unexpected_plot", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pixel_xyc", {14'd0, pix_x, pix_y, colour}, {14'd0, e});
            end
        end
    end

    task automatic push_seg(input int x, input int y, input int col);
        for (int yc = 0; yc < 10; yc++)
            for (int xc = 0; xc < 10; xc++)
                exp_q.push_back({8'(x + xc), 7'(y + yc), 3'(col)});
    endtask

    task automatic model_reset();
        mlen  = 2;
        mdir  = 0;
        mgrow = 1'b0;
        mdead = 1'b0;
        for (int i = 0; i < MAXL; i++) begin
            mx[i] = 39 - 10 * i;
            my[i] = 59;
        end
        exp_q.delete();
        push_seg(mx[0], my[0], 2);
        push_seg(mx[1], my[1], 2);
    endtask

    task automatic model_step();
        bit grew, hit;
        int nx, ny;
        if (mdead) return;
        grew = mgrow && (mlen < MAXL);
        if (!grew) push_seg(mx[mlen-1], my[mlen-1], 0);
        nx = mx[0] + ((mdir == 0) ? 10 : (mdir == 3) ? -10 : 0);
        ny = my[0] + ((mdir == 1) ? 10 : (mdir == 2) ? -10 : 0);
        for (int i = MAXL - 1; i > 0; i--) begin
            mx[i] = mx[i-1];
            my[i] = my[i-1];
        end
        mx[0] = nx;
        my[0] = ny;
        if (grew) mlen++;
        mgrow = 1'b0;
        hit = (nx < 0) || (nx + 10 > 160) || (ny < 0) || (ny + 10 > 120);
        for (int i = 1; i < mlen; i++)
            if (mx[i] == nx && my[i] == ny) hit = 1'b1;
        if (hit) mdead = 1'b1;
        else push_seg(nx, ny, 2);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (busy && !collide && n < 5000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 5000), 32'd1);
        repeat (3) @(negedge CLOCK_50);
        chk({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_head_x"}, 32'(head_x), 32'(mx[0] & 255));
        chk({tag, "_head_y"}, 32'(head_y), 32'(my[0] & 127));
        chk({tag, "_len"}, 32'(len), 32'(mlen));
        chk({tag, "_collide"}, 32'(collide), 32'(mdead));
        chk({tag, "_busy"}, 32'(busy), 32'(mdead));
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge CLOCK_50); #2 Resetn = 1'b0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_pix_x", 32'(pix_x), 32'd0);
        chk("rst_pix_y", 32'(pix_y), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        chk("rst_collide", 32'(collide), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        model_reset();
        plot_cnt = 0;
        mon_en   = 1'b1;
        @(posedge CLOCK_50); #2 Resetn = 1'b1;
        @(negedge CLOCK_50);
        wait_done("init");
        chk("init_plots", 32'(plot_cnt), 32'd200);
        check_state("init");
    endtask

    task automatic pulse_step(input bit dv, input int d, input bit g);
        if (g) begin
            @(posedge CLOCK_50); #2 grow = 1'b1;
            @(posedge CLOCK_50); #2 grow = 1'b0;
            mgrow = 1'b1;
        end
        if (dv) begin
            @(posedge CLOCK_50); #2 dir_valid = 1'b1; dir_req = 2'(d);
            @(posedge CLOCK_50); #2 dir_valid = 1'b0;
            if (d != (~mdir & 3)) mdir = d;
        end
        model_step();
        step = 1'b1;
        @(posedge CLOCK_50); #2 step = 1'b0;
    endtask

    task automatic do_step(input string tag, input bit dv, input int d, input bit g);
        pulse_step(dv, d, g);
        @(negedge CLOCK_50);
        wait_done(tag);
        check_state(tag);
    endtask

    initial begin
        // Initial draw of the two reset segments
        do_reset();

        do_step("move_right", 1'b0, 0, 1'b0);
        do_step("reverse_ignored", 1'b1, 3, 1'b0);
        do_step("turn_down", 1'b1, 1, 1'b0);

        do_step("grow3", 1'b0, 0, 1'b1);
        do_step("grow4", 1'b0, 0, 1'b1);
        do_step("grow5", 1'b0, 0, 1'b1);
        do_step("grow_at_max", 1'b0, 0, 1'b1);

        // Curl back into the body: the third turn lands on the last segment
        do_step("curl_right", 1'b1, 0, 1'b0);
        do_step("curl_up", 1'b1, 2, 1'b0);
        do_step("curl_left", 1'b1, 3, 1'b0);
        chk("self_hit_collide", 32'(collide), 32'd1);

        plot_cnt = 0;
        pulse_step(1'b0, 0, 1'b0);
        repeat (40) @(negedge CLOCK_50);
        chk("dead_no_plot", 32'(plot_cnt), 32'd0);
        chk("dead_collide", 32'(collide), 32'd1);
        chk("dead_busy", 32'(busy), 32'd1);
        chk("dead_head_x", 32'(head_x), 32'd59);

        // Run into the right wall from the reset position
        do_reset();
        for (int i = 0; i < 12; i++) do_step("wall_run", 1'b0, 0, 1'b0);
        chk("wall_collide", 32'(collide), 32'd1);
        chk("wall_head_x", 32'(head_x), 32'd159);

        // Reset in the middle of a head draw
        do_reset();
        pulse_step(1'b0, 0, 1'b0);
        repeat (150) @(negedge CLOCK_50);
        chk("mid_draw_plot", 32'(plot), 32'd1);
        chk("mid_draw_colour", 32'(colour), 32'd2);
        mon_en = 1'b0;
        @(posedge CLOCK_50); #2 Resetn = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("reset_in_draw_plot", 32'(plot), 32'd0);
        chk("reset_in_draw_busy", 32'(busy), 32'd1);
        do_reset();
        do_step("after_reset_move", 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
